// File: rtl/param_register_bank_pkg.sv
// Shared definitions for the parametrised register bank: FSM encodings and a
// constant-foldable ceil(log2) used to size addresses and counters.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    // Smallest r with 2**r >= value; usable in parameter defaults.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/param_register_bank_if.sv
// Datapath / serial-link side bus of the register bank. The master drives the
// commands and address, the slave (the bank) returns read data and serial status.
interface param_register_bank_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 6
);
    logic              load;
    logic              clear;
    logic              flush;
    logic              ser_start;
    logic              output_enable;
    logic [ADDR_W-1:0] reg_select;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;
    logic              busy;
    logic              serial_out;
    logic              ser_valid;
    logic              ser_done;

    modport master (
        output load, clear, flush, ser_start, output_enable, reg_select, data_in,
        input  data_out, busy, serial_out, ser_valid, ser_done
    );

    modport slave (
        input  load, clear, flush, ser_start, output_enable, reg_select, data_in,
        output data_out, busy, serial_out, ser_valid, ser_done
    );
endinterface

// File: rtl/param_register_bank_word_serializer.sv
// LSB-first word serializer. The first bit is registered straight from the
// incoming word on start, so bit k is on serial_out_o k+1 cycles after start;
// done_o accompanies the last bit.
module word_serializer
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] word_i,
    output logic             serial_out_o,
    output logic             ser_valid_o,
    output logic             done_o
);
    localparam int CNT_W = clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic [WIDTH-1:0] sh_q;
    logic [CNT_W-1:0] cnt_q;
    logic             serial_q;
    logic             valid_q;
    logic             done_q;

    // Shift engine: load on start, emit one bit per cycle, retire after WIDTH bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_q     <= '0;
            cnt_q    <= '0;
            serial_q <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else if (start_i) begin
            sh_q     <= word_i >> 1;
            cnt_q    <= CNT_ONE;
            serial_q <= word_i[0];
            valid_q  <= 1'b1;
            done_q   <= 1'b0;
        end else if (valid_q) begin
            if (cnt_q == CNT_FULL) begin
                cnt_q    <= '0;
                serial_q <= 1'b0;
                valid_q  <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                sh_q     <= sh_q >> 1;
                cnt_q    <= cnt_q + CNT_ONE;
                serial_q <= sh_q[0];
                done_q   <= (cnt_q == CNT_LAST);
            end
        end
    end

    assign serial_out_o = serial_q;
    assign ser_valid_o  = valid_q;
    assign done_o       = done_q;

endmodule

// File: rtl/param_register_bank.sv
// DEPTH x WIDTH register bank with parallel load/clear/read, a multi-cycle
// range flush of regs[0..N-1] and a serial shift-out of one register.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | accepts load/clear/flush/ser_start; flush beats ser_start
//   ST_FLUSH | clears regs[fcnt_q] each cycle, returns after regs[N-1]
//   ST_SHIFT | serializer streaming; returns on its done pulse
module param_register_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    param_register_bank_if.slave bus
);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [WIDTH-1:0]  regs_q [DEPTH];
    state_e            state_q;
    logic [ADDR_W-1:0] fcnt_q;
    logic [ADDR_W-1:0] flen_q;
    logic [WIDTH-1:0]  data_out_q;
    logic              ser_accept;
    logic              ser_done_w;
    logic              serial_w;
    logic              ser_valid_w;

    // A flush request, even a zero-length one, takes the slot and drops ser_start.
    assign ser_accept = (state_q == ST_IDLE) && !bus.flush && bus.ser_start;

    // Sequencing FSM together with every write into the register array.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
            flen_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.flush) begin
                        if (bus.reg_select != '0) begin
                            flen_q  <= bus.reg_select;
                            fcnt_q  <= '0;
                            state_q <= ST_FLUSH;
                        end
                    end else begin
                        if (bus.clear)     regs_q[bus.reg_select] <= '0;
                        else if (bus.load) regs_q[bus.reg_select] <= bus.data_in;
                        if (bus.ser_start) state_q <= ST_SHIFT;
                    end
                end
                ST_FLUSH: begin
                    regs_q[fcnt_q] <= '0;
                    if (fcnt_q == flen_q - ADDR_ONE) state_q <= ST_IDLE;
                    else                             fcnt_q  <= fcnt_q + ADDR_ONE;
                end
                ST_SHIFT: begin
                    if (ser_done_w) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Registered read port; shows the pre-write value on a same-cycle write.
    always_ff @(posedge clk) begin
        if (!reset) data_out_q <= '0;
        else        data_out_q <= bus.output_enable ? regs_q[bus.reg_select] : '0;
    end

    word_serializer #(.WIDTH(WIDTH)) u_ser (
        .clk          (clk),
        .reset        (reset),
        .start_i      (ser_accept),
        .word_i       (regs_q[bus.reg_select]),
        .serial_out_o (serial_w),
        .ser_valid_o  (ser_valid_w),
        .done_o       (ser_done_w)
    );

    assign bus.data_out   = data_out_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.serial_out = serial_w;
    assign bus.ser_valid  = ser_valid_w;
    assign bus.ser_done   = ser_done_w;

endmodule

// File: tb/tb_param_register_bank.sv
// Scoreboard bench for param_register_bank: a 32x64 instance (A) and an 8x16
// instance (B). Stimulus pushes expected read data, busy values and serial bits
// into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_param_register_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_c = 1'b0, clear_c = 1'b0, flush_c = 1'b0, start_c = 1'b0, oe_c = 1'b0;
    logic [5:0]  sel_c = '0;
    logic [31:0] din_c = '0;
    logic        en_a = 1'b1, en_b = 1'b0;

    always #5 clk = ~clk;

    param_register_bank_if #(.WIDTH(32), .ADDR_W(6)) ifa ();
    param_register_bank_if #(.WIDTH(8),  .ADDR_W(4)) ifb ();

    assign ifa.load          = en_a & load_c;
    assign ifa.clear         = en_a & clear_c;
    assign ifa.flush         = en_a & flush_c;
    assign ifa.ser_start     = en_a & start_c;
    assign ifa.output_enable = oe_c;
    assign ifa.reg_select    = sel_c;
    assign ifa.data_in       = din_c;

    assign ifb.load          = en_b & load_c;
    assign ifb.clear         = en_b & clear_c;
    assign ifb.flush         = en_b & flush_c;
    assign ifb.ser_start     = en_b & start_c;
    assign ifb.output_enable = oe_c;
    assign ifb.reg_select    = sel_c[3:0];
    assign ifb.data_in       = din_c[7:0];

    param_register_bank #(.WIDTH(32), .DEPTH(64)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    param_register_bank #(.WIDTH(8),  .DEPTH(16)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    logic [31:0] rd_qa[$], rd_qb[$];
    bit          bz_qa[$], bz_qb[$];
    logic [1:0]  ser_qa[$], ser_qb[$];
    int          n_chk = 0, n_fail = 0;
    logic        rd_tag = 1'b0, bz_tag = 1'b0;
    logic        rd_sa = 1'b0, bz_sa = 1'b0, rd_sb = 1'b0, bz_sb = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) begin
        rd_sa <= rd_tag & en_a;
        bz_sa <= bz_tag & en_a;
        rd_sb <= rd_tag & en_b;
        bz_sb <= bz_tag & en_b;
    end

    // Monitor: outputs are stable at the falling edge.
    always @(negedge clk) begin
        logic [1:0] s;
        if (rd_sa && rd_qa.size() > 0) chk("data_out_a", ifa.data_out, rd_qa.pop_front());
        if (bz_sa && bz_qa.size() > 0) chk("busy_a", 32'(ifa.busy), 32'(bz_qa.pop_front()));
        if (ifa.ser_valid === 1'b1) begin
            if (ser_qa.size() > 0) begin
                s = ser_qa.pop_front();
                chk("serial_out_a", 32'(ifa.serial_out), 32'(s[1]));
                chk("ser_done_a", 32'(ifa.ser_done), 32'(s[0]));
            end else chk("ser_valid_a", 32'(ifa.ser_valid), 32'd0);
        end else chk("ser_idle_a", {29'd0, ifa.serial_out, ifa.ser_done, ifa.ser_valid}, 32'd0);

        if (rd_sb && rd_qb.size() > 0) chk("data_out_b", 32'(ifb.data_out), rd_qb.pop_front());
        if (bz_sb && bz_qb.size() > 0) chk("busy_b", 32'(ifb.busy), 32'(bz_qb.pop_front()));
        if (ifb.ser_valid === 1'b1) begin
            if (ser_qb.size() > 0) begin
                s = ser_qb.pop_front();
                chk("serial_out_b", 32'(ifb.serial_out), 32'(s[1]));
                chk("ser_done_b", 32'(ifb.ser_done), 32'(s[0]));
            end else chk("ser_valid_b", 32'(ifb.ser_valid), 32'd0);
        end else chk("ser_idle_b", {29'd0, ifb.serial_out, ifb.ser_done, ifb.ser_valid}, 32'd0);
    end

    // One clock: queue this cycle's expectations, let the edge happen, drop pulses.
    task automatic cyc(input bit rd, input logic [31:0] erd, input bit bz, input bit ebz);
        rd_tag = rd;
        bz_tag = bz;
        if (rd) begin
            if (en_a) rd_qa.push_back(erd);
            if (en_b) rd_qb.push_back(erd & 32'hFF);
        end
        if (bz) begin
            if (en_a) bz_qa.push_back(ebz);
            if (en_b) bz_qb.push_back(ebz);
        end
        @(negedge clk);
        load_c = 1'b0; clear_c = 1'b0; flush_c = 1'b0; start_c = 1'b0;
        rd_tag = 1'b0; bz_tag = 1'b0;
    endtask

    task automatic load_w(input int addr, input logic [31:0] data);
        sel_c = 6'(addr); din_c = data; load_c = 1'b1;
        cyc(0, 0, 0, 0);
    endtask

    task automatic rd(input int addr, input logic [31:0] exp);
        sel_c = 6'(addr); oe_c = 1'b1;
        cyc(1, exp, 0, 0);
    endtask

    task automatic ser_push(input logic [31:0] w, input int width);
        for (int i = 0; i < width; i++) begin
            if (en_a) ser_qa.push_back({w[i], (i == width - 1) ? 1'b1 : 1'b0});
            if (en_b) ser_qb.push_back({w[i], (i == width - 1) ? 1'b1 : 1'b0});
        end
    endtask

    task automatic drain_check(input string name);
        chk(name, 32'(ser_qa.size() + ser_qb.size()), 32'd0);
    endtask

    // Shift of regs[addr]=w, busy high for exactly width cycles.
    task automatic shift_run(input int addr, input logic [31:0] w, input int width);
        sel_c = 6'(addr); start_c = 1'b1;
        ser_push(w, width);
        cyc(0, 0, 1, 1);
        repeat (width - 1) cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 0);
        drain_check("ser_drain");
    endtask

    task automatic test_basic(input int width);
        // load / read / output_enable gating
        load_w(5, 32'hDEAD_BEEF);
        rd(5, 32'hDEAD_BEEF);
        oe_c = 1'b0; sel_c = 6'd5;
        cyc(1, 32'h0, 0, 0);
        // same-cycle write and read shows the old word
        oe_c = 1'b1; sel_c = 6'd5; din_c = 32'h1234_5678; load_c = 1'b1;
        cyc(1, 32'hDEAD_BEEF, 1, 0);
        rd(5, 32'h1234_5678);

        // range flush of regs[0..3], exactly 4 busy cycles
        for (int i = 0; i < 10; i++) load_w(i, 32'(i + 1));
        sel_c = 6'd4; flush_c = 1'b1;
        cyc(0, 0, 1, 1);
        sel_c = 6'd13; din_c = 32'h55; load_c = 1'b1;
        cyc(0, 0, 1, 1);
        sel_c = 6'd0; oe_c = 1'b1;
        cyc(1, 32'h0, 1, 1);
        sel_c = 6'd1;
        cyc(1, 32'h0, 1, 1);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) rd(i, (i < 4) ? 32'h0 : 32'(i + 1));
        rd(13, 32'h0);
        // zero-length flush never raises busy
        sel_c = 6'd0; flush_c = 1'b1;
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);

        // serial shift-out of 0xA5
        load_w(7, 32'h0000_00A5);
        shift_run(7, 32'h0000_00A5, width);
    endtask

    initial begin
        // reset state
        oe_c = 1'b1; sel_c = 6'd5;
        cyc(1, 32'h0, 1, 0);
        cyc(1, 32'h0, 1, 0);
        reset = 1'b1;
        cyc(1, 32'h0, 1, 0);

        test_basic(32);

        // commands during SHIFT are ignored
        sel_c = 6'd7; start_c = 1'b1;
        ser_push(32'h0000_00A5, 32);
        cyc(0, 0, 1, 1);
        sel_c = 6'd7; din_c = 32'hFFFF_FFFF; load_c = 1'b1;
        cyc(0, 0, 1, 1);
        sel_c = 6'd10; flush_c = 1'b1;
        cyc(0, 0, 1, 1);
        sel_c = 6'd7; clear_c = 1'b1;
        cyc(0, 0, 1, 1);
        repeat (28) cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 0);
        drain_check("ser_drain_busy_cmds");
        rd(7, 32'h0000_00A5);
        rd(9, 32'd10);

        // accepted load with ser_start streams the old word
        sel_c = 6'd7; din_c = 32'h0000_0003; load_c = 1'b1;
        shift_run(7, 32'h0000_00A5, 32);
        rd(7, 32'h0000_0003);

        // flush beats ser_start; no serial bits expected
        load_w(0, 32'h11);
        load_w(1, 32'h22);
        sel_c = 6'd2; flush_c = 1'b1; start_c = 1'b1;
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 0);
        rd(0, 32'h0);
        rd(1, 32'h0);
        // clear beats load; plain clear
        load_w(12, 32'h77);
        sel_c = 6'd12; din_c = 32'hAA; load_c = 1'b1; clear_c = 1'b1;
        cyc(0, 0, 0, 0);
        rd(12, 32'h0);
        sel_c = 6'd6; clear_c = 1'b1;
        cyc(0, 0, 0, 0);
        rd(6, 32'h0);

        // reset in the middle of a shift
        load_w(3, 32'hF0F0_F0F0);
        sel_c = 6'd3; start_c = 1'b1;
        ser_push(32'hF0F0_F0F0, 32);
        cyc(0, 0, 1, 1);
        repeat (4) cyc(0, 0, 1, 1);
        reset = 1'b0; oe_c = 1'b1; sel_c = 6'd3;
        cyc(0, 0, 0, 0);
        ser_qa.delete();
        chk("rst_shift_busy", 32'(ifa.busy), 32'd0);
        chk("rst_shift_data_out", ifa.data_out, 32'h0);
        reset = 1'b1;
        cyc(0, 0, 1, 0);
        rd(3, 32'h0);

        // reset in the middle of a flush
        load_w(30, 32'h99);
        load_w(4, 32'h5);
        sel_c = 6'd6; flush_c = 1'b1;
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        reset = 1'b0;
        cyc(0, 0, 0, 0);
        chk("rst_flush_busy", 32'(ifa.busy), 32'd0);
        reset = 1'b1;
        cyc(0, 0, 1, 0);
        rd(30, 32'h0);
        rd(5, 32'h0);
        rd(9, 32'h0);

        // narrow instance: same basic sequence
        en_a = 1'b0; en_b = 1'b1;
        cyc(0, 0, 0, 0);
        test_basic(8);
        en_b = 1'b0;
        repeat (2) cyc(0, 0, 0, 0);
        drain_check("ser_drain_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1);
    end

endmodule
